// File: rtl/iob_clint_tick_pkg.sv
// Shared constants, state encoding and compare arithmetic for the CLINT tick manager.
// Addresses are byte offsets inside the iob_clint register window.
package iob_clint_tick_pkg;

  localparam int unsigned MTIME_LO        = 32'h0000_BFF8;
  localparam int unsigned MTIME_HI        = 32'h0000_BFFC;
  localparam int unsigned CMP_BASE        = 32'h0000_4000;
  localparam int unsigned CMP_STRIDE      = 8;
  localparam int unsigned WAIT_CLR_CYCLES = 4;

  localparam logic [31:0] CMP_HI_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    RD_HI1        = 3'd1,
    RD_LO         = 3'd2,
    RD_HI2        = 3'd3,
    WR_CMP_HI_MAX = 3'd4,
    WR_CMP_LO     = 3'd5,
    WR_CMP_HI     = 3'd6,
    WAIT_CLR      = 3'd7
  } tick_state_e;

  // A zero period would rewrite the compare with the current time, so it is promoted to 1.
  function automatic logic [63:0] add_period(input logic [63:0] now, input logic [63:0] period);
    return now + ((period == 64'd0) ? 64'd1 : period);
  endfunction

endpackage

// File: rtl/iob_clint_tick_req.sv
// Single-transaction IOb initiator: holds a request until accepted, then (for reads)
// waits for rvalid. done_o pulses on write acceptance or read data return.
module iob_clint_tick_req
  import iob_clint_tick_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                we_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o
);

  logic              avalid_q, avalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rwait_q, rwait_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;
  logic              rret;

  always_comb begin
    accept   = avalid_q & iob_ready_i;
    rret     = rwait_q & iob_rvalid_i;
    done_o   = cke_i & ((accept & we_q) | rret);
    rdata_o  = rret ? iob_rdata_i : rdata_q;
    avalid_d = avalid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rwait_d  = rwait_q;
    rdata_d  = rdata_q;
    if (accept) begin
      avalid_d = 1'b0;
      rwait_d  = ~we_q;
    end
    if (rret) begin
      rwait_d = 1'b0;
      rdata_d = iob_rdata_i;
    end
    // A new start may coincide with the previous completion, giving back-to-back requests.
    if (start_i) begin
      avalid_d = 1'b1;
      addr_d   = addr_i;
      wdata_d  = we_i ? wdata_i : '0;
      we_d     = we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rwait_q  <= 1'b0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      avalid_q <= avalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rwait_q  <= rwait_d;
      rdata_q  <= rdata_d;
    end
  end

  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = {(DATA_W/8){we_q}};

endmodule

// File: rtl/iob_clint_tick_mgr.sv
// Periodic mtimecmp reloader: reads mtime glitch-free, adds the period and rewrites
// mtimecmp with the high-word-first safe sequence, on arm and on every serviced mtip.
module iob_clint_tick_mgr
  import iob_clint_tick_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HART_ID  = 0,
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                mtip_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i,
  output logic                tick_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(MTIME_LO);
  localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(MTIME_HI);
  localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(CMP_BASE + CMP_STRIDE * HART_ID);
  localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(CMP_BASE + CMP_STRIDE * HART_ID + 4);
  localparam logic [2:0]        WAIT_LAST  = 3'(WAIT_CLR_CYCLES - 1);

  tick_state_e         state_q, state_d;
  logic                en_q, en_d;
  logic [31:0]         hi1_q, hi1_d;
  logic [31:0]         lo_q, lo_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [63:0]         cmp_q, cmp_d;
  logic [2:0]          wait_q, wait_d;
  logic                overrun_q, overrun_d;

  logic                req_start;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_we;
  logic                req_done;
  logic [DATA_W-1:0]   req_rdata;
  logic                arm;
  logic                service;
  logic                tick;

  iob_clint_tick_req #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cke_i       (cke_i),
    .start_i     (req_start),
    .addr_i      (req_addr),
    .wdata_i     (req_wdata),
    .we_i        (req_we),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i (iob_rdata_i),
    .iob_ready_i (iob_ready_i),
    .done_o      (req_done),
    .rdata_o     (req_rdata)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = en_i;
    hi1_d     = hi1_q;
    lo_d      = lo_q;
    period_d  = period_q;
    cmp_d     = cmp_q;
    wait_d    = wait_q;
    overrun_d = overrun_q;
    req_start = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 1'b0;
    tick      = 1'b0;
    arm       = en_i & ~en_q;
    service   = en_i & mtip_i;

    case (state_q)
      IDLE: begin
        if (service || arm) begin
          tick      = service;
          period_d  = period_i;
          req_start = 1'b1;
          req_addr  = A_MTIME_HI;
          state_d   = RD_HI1;
        end
      end
      RD_HI1: begin
        if (req_done) begin
          hi1_d     = req_rdata[31:0];
          req_start = 1'b1;
          req_addr  = A_MTIME_LO;
          state_d   = RD_LO;
        end
      end
      RD_LO: begin
        if (req_done) begin
          lo_d      = req_rdata[31:0];
          req_start = 1'b1;
          req_addr  = A_MTIME_HI;
          state_d   = RD_HI2;
        end
      end
      RD_HI2: begin
        // A changed high word means the low word wrapped between reads; sample again.
        if (req_done) begin
          req_start = 1'b1;
          if (req_rdata[31:0] != hi1_q) begin
            req_addr = A_MTIME_HI;
            state_d  = RD_HI1;
          end else begin
            cmp_d     = add_period({req_rdata[31:0], lo_q}, 64'(period_q));
            req_addr  = A_CMP_HI;
            req_wdata = DATA_W'(CMP_HI_MAX);
            req_we    = 1'b1;
            state_d   = WR_CMP_HI_MAX;
          end
        end
      end
      WR_CMP_HI_MAX: begin
        if (req_done) begin
          req_start = 1'b1;
          req_addr  = A_CMP_LO;
          req_wdata = DATA_W'(cmp_q[31:0]);
          req_we    = 1'b1;
          state_d   = WR_CMP_LO;
        end
      end
      WR_CMP_LO: begin
        if (req_done) begin
          req_start = 1'b1;
          req_addr  = A_CMP_HI;
          req_wdata = DATA_W'(cmp_q[63:32]);
          req_we    = 1'b1;
          state_d   = WR_CMP_HI;
        end
      end
      WR_CMP_HI: begin
        if (req_done) begin
          wait_d  = 3'd0;
          state_d = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        // mtip still high after the grace window means the new compare is already past.
        if (!mtip_i) begin
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          overrun_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      hi1_q     <= '0;
      lo_q      <= '0;
      period_q  <= '0;
      cmp_q     <= '0;
      wait_q    <= '0;
      overrun_q <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      en_q      <= en_d;
      hi1_q     <= hi1_d;
      lo_q      <= lo_d;
      period_q  <= period_d;
      cmp_q     <= cmp_d;
      wait_q    <= wait_d;
      overrun_q <= overrun_d;
    end
  end

  assign tick_o    = tick & rst_n_i & cke_i;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_iob_clint_tick_mgr.sv
// Directed bench for iob_clint_tick_mgr with HART_ID = 2: a small CLINT responder
// logs every accepted request and the initial block checks it against hand values.
module tb_iob_clint_tick_mgr;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        cke_i;
  logic        en_i;
  logic [31:0] period_i;
  logic        mtip_i;
  logic        iob_avalid_o;
  logic [15:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_rvalid_i = 1'b0;
  logic [31:0] iob_rdata_i  = 32'h0;
  logic        iob_ready_i  = 1'b0;
  logic        tick_o;
  logic        busy_o;
  logic        overrun_o;

  always #5 clk = ~clk;

  iob_clint_tick_mgr #(
    .ADDR_W  (16),
    .DATA_W  (32),
    .HART_ID (2),
    .PERIOD_W(32)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .cke_i       (cke_i),
    .en_i        (en_i),
    .period_i    (period_i),
    .mtip_i      (mtip_i),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i (iob_rdata_i),
    .iob_ready_i (iob_ready_i),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  int checks = 0;
  int passes = 0;

  bit          bp_mode   = 1'b0;
  bit          rand_mode = 1'b1;
  logic [63:0] mtime     = 64'h0;
  logic [31:0] rd_tab [0:15];
  int          rd_n      = 0;

  int          cyc       = 0;
  int          trig_cyc  = 0;
  int          tick_cnt  = 0;
  int          stab_err  = 0;
  int          stall_cnt = 0;
  int          rd_idx    = 0;
  bit          rd_pend   = 1'b0;
  bit          prev_hold = 1'b0;
  bit          en_prev   = 1'b0;
  logic [31:0] rd_val    = 32'h0;
  logic [15:0] prev_addr = 16'h0;
  logic [31:0] prev_wdata = 32'h0;
  logic [3:0]  prev_wstrb = 4'h0;
  logic [31:0] cmp_lo    = 32'h0;
  logic [31:0] cmp_hi    = 32'h0;
  logic [15:0] log_addr  [$];
  logic [31:0] log_wdata [$];
  logic [3:0]  log_wstrb [$];
  int          log_cyc   [$];

  // CLINT responder: logs accepted requests, returns read data one cycle after acceptance.
  always @(posedge clk) begin
    cyc++;
    if (rst_n_i && tick_o) tick_cnt++;
    if (rst_n_i && en_i && !en_prev) trig_cyc = cyc;
    en_prev = en_i;
    if (prev_hold) begin
      if (!(iob_avalid_o && iob_addr_o == prev_addr && iob_wdata_o == prev_wdata &&
            iob_wstrb_o == prev_wstrb))
        stab_err++;
    end
    prev_hold  = rst_n_i && iob_avalid_o && !iob_ready_i;
    prev_addr  = iob_addr_o;
    prev_wdata = iob_wdata_o;
    prev_wstrb = iob_wstrb_o;
    rd_pend    = 1'b0;
    if (rst_n_i && cke_i && iob_avalid_o && iob_ready_i) begin
      log_addr.push_back(iob_addr_o);
      log_wdata.push_back(iob_wdata_o);
      log_wstrb.push_back(iob_wstrb_o);
      log_cyc.push_back(cyc);
      stall_cnt = 0;
      if (iob_wstrb_o == 4'hF) begin
        if (iob_addr_o == 16'h4010) cmp_lo = iob_wdata_o;
        else if (iob_addr_o == 16'h4014) cmp_hi = iob_wdata_o;
      end else begin
        rd_pend = 1'b1;
        if (rd_idx < rd_n) begin
          rd_val = rd_tab[rd_idx];
          rd_idx++;
        end else begin
          rd_val = (iob_addr_o == 16'hBFF8) ? mtime[31:0] : mtime[63:32];
        end
      end
    end else if (iob_avalid_o) begin
      stall_cnt++;
    end
    #1;
    if (rand_mode) begin
      iob_rvalid_i = 1'($urandom);
      iob_rdata_i  = $urandom;
      iob_ready_i  = 1'($urandom);
    end else begin
      iob_rvalid_i = rd_pend;
      iob_rdata_i  = rd_pend ? rd_val : 32'h0;
      iob_ready_i  = !bp_mode || (stall_cnt >= 5);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic en, input logic mtip, input logic [31:0] period);
    @(negedge clk);
    en_i     = en;
    mtip_i   = mtip;
    period_i = period;
  endtask

  task automatic waitIdle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
  endtask

  task automatic checkTxn(input string tag, input int idx, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    checkOutput({tag, "_addr"},  64'(log_addr[idx]),  64'(addr));
    checkOutput({tag, "_wdata"}, 64'(log_wdata[idx]), 64'(wdata));
    checkOutput({tag, "_wstrb"}, 64'(log_wstrb[idx]), 64'(wstrb));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int tbase;
    int sbase;

    rst_n_i  = 1'b0;
    cke_i    = 1'b1;
    en_i     = 1'b0;
    mtip_i   = 1'b0;
    period_i = 32'h0;

    // Reset held three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_avalid",  64'(iob_avalid_o), 64'h0);
      checkOutput("rst_addr",    64'(iob_addr_o),   64'h0);
      checkOutput("rst_wdata",   64'(iob_wdata_o),  64'h0);
      checkOutput("rst_wstrb",   64'(iob_wstrb_o),  64'h0);
      checkOutput("rst_tick",    64'(tick_o),       64'h0);
      checkOutput("rst_busy",    64'(busy_o),       64'h0);
      checkOutput("rst_overrun", 64'(overrun_o),    64'h0);
      en_i     = 1'($urandom);
      mtip_i   = 1'($urandom);
      period_i = $urandom;
      cke_i    = 1'($urandom);
    end
    @(negedge clk);
    rst_n_i   = 1'b1;
    rand_mode = 1'b0;
    cke_i     = 1'b1;
    en_i      = 1'b0;
    mtip_i    = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_avalid", 64'(iob_avalid_o), 64'h0);
    checkOutput("post_rst_busy",   64'(busy_o),       64'h0);
    checkOutput("post_rst_nreq",   64'(log_addr.size()), 64'h0);

    // Arm: mtime 0x1_FFFF_FF00 + 0x200 = 0x2_0000_0100.
    mtime = 64'h0000_0001_FFFF_FF00;
    base  = log_addr.size();
    tbase = tick_cnt;
    applyStimulus(1'b1, 1'b0, 32'h200);
    @(negedge clk);
    checkOutput("arm_busy", 64'(busy_o), 64'h1);
    waitIdle(100);
    checkOutput("arm_idle", 64'(busy_o), 64'h0);
    checkOutput("arm_nreq", 64'(log_addr.size() - base), 64'd6);
    checkTxn("arm_rd_hi1", base + 0, 16'hBFFC, 32'h0, 4'h0);
    checkTxn("arm_rd_lo",  base + 1, 16'hBFF8, 32'h0, 4'h0);
    checkTxn("arm_rd_hi2", base + 2, 16'hBFFC, 32'h0, 4'h0);
    checkTxn("arm_wr_max", base + 3, 16'h4014, 32'hFFFF_FFFF, 4'hF);
    checkTxn("arm_wr_lo",  base + 4, 16'h4010, 32'h0000_0100, 4'hF);
    checkTxn("arm_wr_hi",  base + 5, 16'h4014, 32'h0000_0002, 4'hF);
    checkOutput("arm_latency", 64'(log_cyc[base + 5] - trig_cyc), 64'd9);
    checkOutput("arm_tick",    64'(tick_cnt - tbase), 64'd0);

    // Wrap retry: first HI pair differs, second agrees.
    applyStimulus(1'b0, 1'b0, 32'h100);
    rd_tab[0] = 32'h1; rd_tab[1] = 32'h10; rd_tab[2] = 32'h2;
    rd_tab[3] = 32'h2; rd_tab[4] = 32'h20; rd_tab[5] = 32'h2;
    rd_n = rd_idx + 6;
    base = log_addr.size();
    applyStimulus(1'b1, 1'b0, 32'h100);
    waitIdle(150);
    checkOutput("wrap_idle",  64'(busy_o), 64'h0);
    checkOutput("wrap_nreq",  64'(log_addr.size() - base), 64'd9);
    checkOutput("wrap_rd4",   64'(log_addr[base + 3]), 64'hBFFC);
    checkOutput("wrap_rd6",   64'(log_wstrb[base + 5]), 64'h0);
    checkOutput("wrap_wr1",   64'(log_wstrb[base + 6]), 64'hF);
    checkOutput("wrap_cmp",   {cmp_hi, cmp_lo}, 64'h0000_0002_0000_0120);

    // Backpressure: five stall cycles per request, period 0 behaves as 1.
    applyStimulus(1'b0, 1'b0, 32'h0);
    bp_mode = 1'b1;
    mtime   = 64'h0000_0005_0000_0010;
    base    = log_addr.size();
    sbase   = stab_err;
    applyStimulus(1'b1, 1'b0, 32'h0);
    waitIdle(300);
    checkOutput("bp_idle",    64'(busy_o), 64'h0);
    checkOutput("bp_stable",  64'(stab_err - sbase), 64'd0);
    checkOutput("bp_nreq",    64'(log_addr.size() - base), 64'd6);
    checkTxn("bp_rd_hi1", base + 0, 16'hBFFC, 32'h0, 4'h0);
    checkTxn("bp_rd_lo",  base + 1, 16'hBFF8, 32'h0, 4'h0);
    checkTxn("bp_wr_max", base + 3, 16'h4014, 32'hFFFF_FFFF, 4'hF);
    checkTxn("bp_wr_lo",  base + 4, 16'h4010, 32'h0000_0011, 4'hF);
    checkTxn("bp_wr_hi",  base + 5, 16'h4014, 32'h0000_0005, 4'hF);
    checkOutput("bp_latency", 64'(log_cyc[base + 5] - trig_cyc), 64'd39);
    bp_mode = 1'b0;

    // Overrun: arm, one mtip pulse, then mtip held through the grace window.
    applyStimulus(1'b0, 1'b0, 32'h40);
    mtime = 64'h0000_0000_0000_1000;
    applyStimulus(1'b1, 1'b0, 32'h40);
    waitIdle(100);
    tbase = tick_cnt;
    applyStimulus(1'b1, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h40);
    waitIdle(100);
    checkOutput("ovr_pulse_tick", 64'(tick_cnt - tbase), 64'd1);
    checkOutput("ovr_pulse_flag", 64'(overrun_o), 64'h0);
    checkOutput("ovr_pulse_cmp",  {cmp_hi, cmp_lo}, 64'h0000_0000_0000_1040);
    applyStimulus(1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (overrun_o) break;
    end
    checkOutput("ovr_flag",      64'(overrun_o), 64'h1);
    checkOutput("ovr_retrig",    64'(tick_o), 64'h1);
    checkOutput("ovr_held_tick", 64'(tick_cnt - tbase), 64'd2);
    applyStimulus(1'b0, 1'b0, 32'h40);
    checkOutput("ovr_restart",   64'(busy_o), 64'h1);
    waitIdle(100);
    checkOutput("ovr_end_idle",  64'(busy_o), 64'h0);
    checkOutput("ovr_end_tick",  64'(tick_cnt - tbase), 64'd3);
    checkOutput("ovr_sticky",    64'(overrun_o), 64'h1);

    // Reset while the CMP_LO write is stalled.
    bp_mode = 1'b1;
    base    = log_addr.size();
    applyStimulus(1'b1, 1'b0, 32'h40);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (log_addr.size() == base + 4 && iob_avalid_o && iob_addr_o == 16'h4010) break;
    end
    checkOutput("rmid_addr",  64'(iob_addr_o),  64'h4010);
    checkOutput("rmid_wstrb", 64'(iob_wstrb_o), 64'hF);
    en_i    = 1'b0;
    rst_n_i = 1'b0;
    @(negedge clk);
    checkOutput("rmid_avalid",  64'(iob_avalid_o), 64'h0);
    checkOutput("rmid_busy",    64'(busy_o),       64'h0);
    checkOutput("rmid_overrun", 64'(overrun_o),    64'h0);
    rst_n_i = 1'b1;
    bp_mode = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rmid_nreq",     64'(log_addr.size() - base), 64'd4);
    checkOutput("rmid_avalid2",  64'(iob_avalid_o), 64'h0);
    checkOutput("rmid_busy2",    64'(busy_o),       64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
